// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM; define MULTICYCLE_DIV_EN to accept the div funct (011010)
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;
    state_t cur, nxt;
    logic [3:0] r_ctl;
    logic       r_legal;
    always_ff @(posedge clk) cur <= reset ? FETCH : nxt;
    always_comb begin
        r_ctl   = 4'b0000;
        r_legal = 1'b1;
        case (funct)
            6'b100000: r_ctl = 4'b0010;
            6'b100010: r_ctl = 4'b0110;
            6'b100100: r_ctl = 4'b0000;
            6'b100101: r_ctl = 4'b0001;
            6'b101010: r_ctl = 4'b0111;
`ifdef MULTICYCLE_DIV_EN
            6'b011010: r_ctl = 4'b0101;
`endif
            default:   r_legal = 1'b0;
        endcase
    end
    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        alu_control = 4'b0000;
        nxt         = FETCH;
        case (cur)
            FETCH: begin
                mem_read    = 1'b1;
                ir_write    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 4'b0010;
                pc_en       = 1'b1;
                nxt         = DECODE;
            end
            DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 4'b0010;
                nxt = opcode == 6'b000000 ? EXEC :
                      (opcode == 6'b100011 || opcode == 6'b101011) ? MEMADR :
                      opcode == 6'b000100 ? BRANCH :
                      opcode == 6'b000010 ? JUMP :
                      opcode == 6'b001000 ? ADDIEX : FETCH;
            end
            MEMADR, ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 4'b0010;
                nxt = cur == ADDIEX ? ADDIWB : opcode == 6'b101011 ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                nxt      = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = r_ctl;
                nxt         = r_legal ? ALUWB : FETCH;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 4'b0110;
                pc_source   = 2'b01;
                pc_en       = zero;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            default: nxt = FETCH;
        endcase
        if (reset) begin
            pc_en     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end
    assign state = reset ? 4'd0 : cur;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-004 SHALL have outputs, 1 bit each: pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a.
REQ-005 SHALL have outputs: alu_src_b  out  2  (00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2); pc_source  out  2  (00 ALU result, 01 ALUOut reg, 10 jump target); alu_control  out  4  ALU op; state  out  4  debug state code.

Function
REQ-006 SHALL be a Moore FSM; outputs depend on state only, except alu_control in EXEC (funct) and pc_en in BRANCH (zero).
REQ-007 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-008 SHALL drive alu_control with: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 0101 div.
REQ-009 SHALL drive every output not listed for a state to 0.
REQ-010 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_control=0010, pc_en=1; next DECODE.
REQ-011 DECODE: alu_src_b=11, alu_control=0010; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, any other->FETCH.
REQ-012 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=0010; MEMADR next MEMRD (100011) or MEMWR (101011); ADDIEX next ADDIWB.
REQ-013 MEMRD: mem_read=1, iord=1, next MEMWB; MEMWB: reg_write=1, mem_to_reg=1, next FETCH.
REQ-014 MEMWR: mem_write=1, iord=1; next FETCH.
REQ-015 EXEC: alu_src_a=1, alu_src_b=00; funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; next ALUWB for legal funct, FETCH otherwise (no register write).
REQ-016 ALUWB: reg_write=1, reg_dst=1; ADDIWB: reg_write=1; both next FETCH.
REQ-017 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=0110, pc_source=01, pc_en=zero; next FETCH.
REQ-018 JUMP: pc_source=10, pc_en=1; next FETCH.
REQ-019 SHALL complete in cycles: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5, illegal opcode 2.
REQ-020 SHALL sample opcode/funct only combinationally in DECODE, MEMADR, EXEC; inputs elsewhere are don't-care.
REQ-021 SHALL treat unused state codes 12-15 as FETCH-bound: all outputs 0, next FETCH.

Reset
REQ-022 reset=1 at a rising edge SHALL load FETCH regardless of current state, including mid-instruction.
REQ-023 While reset=1, SHALL force pc_en, mem_read, mem_write, ir_write, reg_write to 0 and state output to 0.
REQ-024 First cycle after reset deasserts SHALL be FETCH with REQ-010 outputs.

Configuration
REQ-025 Macro MULTICYCLE_DIV_EN defined: funct 011010 in EXEC SHALL yield alu_control=0101 and proceed to ALUWB.
REQ-026 Macro undefined: funct 011010 SHALL be illegal per REQ-015 (alu_control=0000, next FETCH, no write).

Verification
REQ-027 Reset held 2 cycles, release -> state=0, pc_en=1, ir_write=1, alu_src_b=01 in first cycle.
REQ-028 opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-029 opcode=000100, zero=1 then zero=0 -> sequence 0,1,8,0; pc_en=1 in state 8 only when zero=1; pc_source=01.
REQ-030 opcode=000000, funct=101010 -> EXEC alu_control=0111, then ALUWB reg_write=1, reg_dst=1; funct=011010 -> 0101+ALUWB with MULTICYCLE_DIV_EN, 0000+FETCH without.
REQ-031 opcode=111111 -> sequence 0,1,0; no mem_write/reg_write ever asserted.
REQ-032 reset asserted in MEMRD of lw -> next state 0, reg_write never asserted for that lw.
